// File: rtl/ex_forward_scoreboard_pkg.sv
// Shared constants for the EX-stage hazard logic: instruction opcode classes
// and the default register index width.
package ex_hazard_pkg;

    localparam int DEFAULT_REG_ADDR_W = 5;

    localparam logic [6:0] IMME_ARITH = 7'b0010011;
    localparam logic [6:0] ARITH      = 7'b0110011;
    localparam logic [6:0] COND_JMP   = 7'b1100011;
    localparam logic [6:0] UNCOND_JMP = 7'b1101111;
    localparam logic [6:0] LOAD       = 7'b0000011;
    localparam logic [6:0] STORE      = 7'b0100011;

endpackage

// File: rtl/ex_forward_scoreboard_fwd_mux.sv
// One source channel's forwarding select: EX_MEM beats MEM_WB beats WB-hold,
// and register x0 is never forwarded at any level.
module ex_fwd_mux
    import ex_hazard_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int WB_BYPASS  = 1
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  rs_used,
    input  logic                  ex_mem_regwrite,
    input  logic                  ex_mem_memread,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic [XLEN-1:0]       ex_mem_data,
    input  logic                  mem_wb_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic [XLEN-1:0]       mem_wb_data,
    input  logic                  hold_valid,
    input  logic [REG_ADDR_W-1:0] hold_rd,
    input  logic [XLEN-1:0]       hold_data,
    output logic [XLEN-1:0]       fwd_data,
    output logic                  fwd_enable
);

    // A load sitting in EX_MEM has no data yet, so it must not win the EX_MEM level.
    always_comb begin
        fwd_data   = '0;
        fwd_enable = 1'b0;
        if (rs_used && (rs != '0)) begin
            if (ex_mem_regwrite && !ex_mem_memread && (ex_mem_rd != '0) && (ex_mem_rd == rs)) begin
                fwd_data   = ex_mem_data;
                fwd_enable = 1'b1;
            end else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs)) begin
                fwd_data   = mem_wb_data;
                fwd_enable = 1'b1;
            end else if ((WB_BYPASS != 0) && hold_valid && (hold_rd != '0) && (hold_rd == rs)) begin
                fwd_data   = hold_data;
                fwd_enable = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_forward_scoreboard.sv
// EX-stage forwarding and hazard unit: per-channel operand forwarding plus a
// pending-load scoreboard that stalls EX until a needed load result is forwardable.
module ex_forward_scoreboard
    import ex_hazard_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int REG_ADDR_W      = DEFAULT_REG_ADDR_W,
    parameter int NUM_SRC         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WB_BYPASS       = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ID_EX_rs,
    input  logic [NUM_SRC-1:0]            ID_EX_rs_used,
    input  logic [REG_ADDR_W-1:0]         ID_EX_rd,
    input  logic                          ID_EX_memread,
    input  logic                          ex_valid,
    input  logic                          flush,
    input  logic [REG_ADDR_W-1:0]         EX_MEM_rd,
    input  logic                          EX_MEM_regwrite,
    input  logic                          EX_MEM_memread,
    input  logic [XLEN-1:0]               EX_MEM_ALU_result,
    input  logic [REG_ADDR_W-1:0]         MEM_WB_rd,
    input  logic                          MEM_WB_regwrite,
    input  logic [XLEN-1:0]               MEM_WB_result,
    input  logic                          mem_resp_valid,
    input  logic [REG_ADDR_W-1:0]         mem_resp_rd,
    output logic [NUM_SRC*XLEN-1:0]       EX_hazard_data,
    output logic [NUM_SRC-1:0]            EX_hazard_data_enable,
    output logic                          EX_stall,
    output logic                          load_full,
    output logic [31:0]                   stall_cycles,
    output logic                          sb_error
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  wb_hold_valid_q;
    logic [REG_ADDR_W-1:0] wb_hold_rd_q;
    logic [XLEN-1:0]       wb_hold_data_q;
    logic [31:0]           stall_cycles_q;
    logic                  sb_error_q;

    logic [NUM_SRC-1:0]    src_hit;
    logic                  resp_ok;
    logic                  issue_load;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [REG_ADDR_W-1:0] rs;
        assign rs = ID_EX_rs[s*REG_ADDR_W +: REG_ADDR_W];

        // A response arriving this cycle for rs is forwardable from MEM_WB, so it is not a hit.
        assign src_hit[s] = ID_EX_rs_used[s] && (rs != '0) && pending_q[rs]
                            && !(mem_resp_valid && (mem_resp_rd == rs));

        ex_fwd_mux #(
            .XLEN       (XLEN),
            .REG_ADDR_W (REG_ADDR_W),
            .WB_BYPASS  (WB_BYPASS)
        ) u_fwd_mux (
            .rs              (rs),
            .rs_used         (ID_EX_rs_used[s]),
            .ex_mem_regwrite (EX_MEM_regwrite),
            .ex_mem_memread  (EX_MEM_memread),
            .ex_mem_rd       (EX_MEM_rd),
            .ex_mem_data     (EX_MEM_ALU_result),
            .mem_wb_regwrite (MEM_WB_regwrite),
            .mem_wb_rd       (MEM_WB_rd),
            .mem_wb_data     (MEM_WB_result),
            .hold_valid      (wb_hold_valid_q),
            .hold_rd         (wb_hold_rd_q),
            .hold_data       (wb_hold_data_q),
            .fwd_data        (EX_hazard_data[s*XLEN +: XLEN]),
            .fwd_enable      (EX_hazard_data_enable[s])
        );
    end

    assign load_full  = (outstanding_q == CNT_MAX);
    assign EX_stall   = ex_valid && !flush
                        && ((|src_hit) || (ID_EX_memread && load_full && !mem_resp_valid));
    assign issue_load = ex_valid && !flush && !EX_stall && ID_EX_memread;
    assign resp_ok    = mem_resp_valid && (outstanding_q != '0) && pending_q[mem_resp_rd];

    assign stall_cycles = stall_cycles_q;
    assign sb_error     = sb_error_q;

    // Clear on a good response first, then set on issue, so a same-register set wins.
    // A full counter with only a bogus response cannot grow past MAX_OUTSTANDING.
    always_comb begin
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        if (resp_ok) begin
            pending_d[mem_resp_rd] = 1'b0;
        end
        if (issue_load && (ID_EX_rd != '0)) begin
            pending_d[ID_EX_rd] = 1'b1;
        end
        if (issue_load && !resp_ok && !load_full) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!issue_load && resp_ok) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q       <= '0;
            outstanding_q   <= '0;
            wb_hold_valid_q <= 1'b0;
            wb_hold_rd_q    <= '0;
            wb_hold_data_q  <= '0;
            stall_cycles_q  <= '0;
            sb_error_q      <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            outstanding_q   <= outstanding_d;
            wb_hold_valid_q <= MEM_WB_regwrite && (MEM_WB_rd != '0);
            wb_hold_rd_q    <= MEM_WB_rd;
            wb_hold_data_q  <= MEM_WB_result;
            if (EX_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (mem_resp_valid && !resp_ok) begin
                sb_error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_forward_scoreboard.sv
// Directed bench for ex_forward_scoreboard: stimulus pushes expected outputs into a
// queue and a negedge monitor pops and compares them against the DUT.
module tb_ex_forward_scoreboard;

    typedef struct {
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [1:0]  used;
        logic [4:0]  id_rd;
        logic        id_mr;
        logic        exv;
        logic        fl;
        logic [4:0]  exm_rd;
        logic        exm_rw;
        logic        exm_mr;
        logic [31:0] exm_data;
        logic [4:0]  mwb_rd;
        logic        mwb_rw;
        logic [31:0] mwb_data;
        logic        rv;
        logic [4:0]  rrd;
    } stim_t;

    typedef struct {
        int          id;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  en;
        logic        stall;
        logic        full;
        logic        err;
        logic        chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [9:0]  ID_EX_rs;
    logic [1:0]  ID_EX_rs_used;
    logic [4:0]  ID_EX_rd;
    logic        ID_EX_memread;
    logic        ex_valid;
    logic        flush;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_regwrite;
    logic        EX_MEM_memread;
    logic [31:0] EX_MEM_ALU_result;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regwrite;
    logic [31:0] MEM_WB_result;
    logic        mem_resp_valid;
    logic [4:0]  mem_resp_rd;
    logic [63:0] EX_hazard_data;
    logic [1:0]  EX_hazard_data_enable;
    logic        EX_stall;
    logic        load_full;
    logic [31:0] stall_cycles;
    logic        sb_error;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    ex_forward_scoreboard dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ID_EX_rs              (ID_EX_rs),
        .ID_EX_rs_used         (ID_EX_rs_used),
        .ID_EX_rd              (ID_EX_rd),
        .ID_EX_memread         (ID_EX_memread),
        .ex_valid              (ex_valid),
        .flush                 (flush),
        .EX_MEM_rd             (EX_MEM_rd),
        .EX_MEM_regwrite       (EX_MEM_regwrite),
        .EX_MEM_memread        (EX_MEM_memread),
        .EX_MEM_ALU_result     (EX_MEM_ALU_result),
        .MEM_WB_rd             (MEM_WB_rd),
        .MEM_WB_regwrite       (MEM_WB_regwrite),
        .MEM_WB_result         (MEM_WB_result),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_rd           (mem_resp_rd),
        .EX_hazard_data        (EX_hazard_data),
        .EX_hazard_data_enable (EX_hazard_data_enable),
        .EX_stall              (EX_stall),
        .load_full             (load_full),
        .stall_cycles          (stall_cycles),
        .sb_error              (sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idleStim();
        stim_t s;
        s.rs0 = '0; s.rs1 = '0; s.used = '0; s.id_rd = '0; s.id_mr = 1'b0;
        s.exv = 1'b0; s.fl = 1'b0;
        s.exm_rd = '0; s.exm_rw = 1'b0; s.exm_mr = 1'b0; s.exm_data = '0;
        s.mwb_rd = '0; s.mwb_rw = 1'b0; s.mwb_data = '0;
        s.rv = 1'b0; s.rrd = '0;
        return s;
    endfunction

    function automatic exp_t mkExp(int id, logic [31:0] d0, logic [31:0] d1, logic [1:0] en,
                                   logic stall, logic full, logic err);
        exp_t e;
        e.id = id; e.d0 = d0; e.d1 = d1; e.en = en;
        e.stall = stall; e.full = full; e.err = err;
        e.chk_cnt = 1'b0; e.cnt = '0;
        return e;
    endfunction

    function automatic exp_t withCnt(exp_t e, logic [31:0] cnt);
        exp_t r;
        r = e;
        r.chk_cnt = 1'b1;
        r.cnt = cnt;
        return r;
    endfunction

    task automatic applyStimulus(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        ID_EX_rs          = {s.rs1, s.rs0};
        ID_EX_rs_used     = s.used;
        ID_EX_rd          = s.id_rd;
        ID_EX_memread     = s.id_mr;
        ex_valid          = s.exv;
        flush             = s.fl;
        EX_MEM_rd         = s.exm_rd;
        EX_MEM_regwrite   = s.exm_rw;
        EX_MEM_memread    = s.exm_mr;
        EX_MEM_ALU_result = s.exm_data;
        MEM_WB_rd         = s.mwb_rd;
        MEM_WB_regwrite   = s.mwb_rw;
        MEM_WB_result     = s.mwb_data;
        mem_resp_valid    = s.rv;
        mem_resp_rd       = s.rrd;
        exp_q.push_back(e);
    endtask

    task automatic compareField(input int id, input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL step%0d %s: got %h expected %h", id, name, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField(e.id, "data0", EX_hazard_data[31:0], e.d0);
        compareField(e.id, "data1", EX_hazard_data[63:32], e.d1);
        compareField(e.id, "enable", {30'd0, EX_hazard_data_enable}, {30'd0, e.en});
        compareField(e.id, "EX_stall", {31'd0, EX_stall}, {31'd0, e.stall});
        compareField(e.id, "load_full", {31'd0, load_full}, {31'd0, e.full});
        compareField(e.id, "sb_error", {31'd0, sb_error}, {31'd0, e.err});
        if (e.chk_cnt) begin
            compareField(e.id, "stall_cycles", stall_cycles, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e);
        end
    end

    initial begin
        stim_t s;
        int    wait_cycles;

        rst_n = 1'b0;
        s = idleStim();
        ID_EX_rs = '0; ID_EX_rs_used = '0; ID_EX_rd = '0; ID_EX_memread = 1'b0;
        ex_valid = 1'b0; flush = 1'b0;
        EX_MEM_rd = '0; EX_MEM_regwrite = 1'b0; EX_MEM_memread = 1'b0; EX_MEM_ALU_result = '0;
        MEM_WB_rd = '0; MEM_WB_regwrite = 1'b0; MEM_WB_result = '0;
        mem_resp_valid = 1'b0; mem_resp_rd = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        s = idleStim();
        applyStimulus(s, withCnt(mkExp(0, 0, 0, 2'b00, 0, 0, 0), 0));

        // EX_MEM ALU forward of x5; channel 1 reads x5 but is unused
        s = idleStim(); s.exv = 1; s.rs0 = 5; s.rs1 = 5; s.used = 2'b01;
        s.exm_rd = 5; s.exm_rw = 1; s.exm_data = 32'h11;
        applyStimulus(s, mkExp(1, 32'h11, 0, 2'b01, 0, 0, 0));

        // EX_MEM has priority over MEM_WB for x8
        s = idleStim(); s.exv = 1; s.rs0 = 8; s.rs1 = 8; s.used = 2'b11;
        s.exm_rd = 8; s.exm_rw = 1; s.exm_data = 32'h33;
        s.mwb_rd = 8; s.mwb_rw = 1; s.mwb_data = 32'h44;
        applyStimulus(s, mkExp(2, 32'h33, 32'h33, 2'b11, 0, 0, 0));

        // Load in EX_MEM is not forwardable: falls through to MEM_WB
        s.exm_mr = 1;
        applyStimulus(s, mkExp(3, 32'h44, 32'h44, 2'b11, 0, 0, 0));

        // MEM_WB writes x7, then x7 read next cycle comes from the WB hold register
        s = idleStim(); s.mwb_rd = 7; s.mwb_rw = 1; s.mwb_data = 32'h22;
        applyStimulus(s, mkExp(4, 0, 0, 2'b00, 0, 0, 0));
        s = idleStim(); s.exv = 1; s.rs0 = 7; s.used = 2'b01;
        applyStimulus(s, mkExp(5, 32'h22, 0, 2'b01, 0, 0, 0));
        applyStimulus(s, mkExp(6, 0, 0, 2'b00, 0, 0, 0));

        // Load x6, dependent read stalls until the response arrives
        s = idleStim(); s.exv = 1; s.id_mr = 1; s.id_rd = 6;
        applyStimulus(s, mkExp(7, 0, 0, 2'b00, 0, 0, 0));
        s = idleStim(); s.exv = 1; s.rs1 = 6; s.used = 2'b10;
        applyStimulus(s, mkExp(8, 0, 0, 2'b00, 1, 0, 0));
        applyStimulus(s, mkExp(9, 0, 0, 2'b00, 1, 0, 0));
        s.rv = 1; s.rrd = 6; s.mwb_rd = 6; s.mwb_rw = 1; s.mwb_data = 32'hAB;
        applyStimulus(s, withCnt(mkExp(10, 0, 32'hAB, 2'b10, 0, 0, 0), 2));

        // Fill the load tracker with x10..x13
        for (int i = 0; i < 4; i++) begin
            s = idleStim(); s.exv = 1; s.id_mr = 1; s.id_rd = 5'(10 + i);
            applyStimulus(s, mkExp(11 + i, 0, 0, 2'b00, 0, 0, 0));
        end
        s = idleStim();
        applyStimulus(s, mkExp(15, 0, 0, 2'b00, 0, 1, 0));

        // Flushed instruction never stalls even on a pending source
        s = idleStim(); s.exv = 1; s.fl = 1; s.rs0 = 10; s.used = 2'b01;
        applyStimulus(s, mkExp(16, 0, 0, 2'b00, 0, 1, 0));

        // Fifth load stalls while full, issues alongside a response
        s = idleStim(); s.exv = 1; s.id_mr = 1; s.id_rd = 14;
        applyStimulus(s, mkExp(17, 0, 0, 2'b00, 1, 1, 0));
        s.rv = 1; s.rrd = 10; s.mwb_rd = 10; s.mwb_rw = 1; s.mwb_data = 32'h55;
        applyStimulus(s, mkExp(18, 0, 0, 2'b00, 0, 1, 0));
        s = idleStim();
        applyStimulus(s, withCnt(mkExp(19, 0, 0, 2'b00, 0, 1, 0), 3));

        // Retire x11, then an x0 load: counted, never pending, x0 never forwarded
        s = idleStim(); s.rv = 1; s.rrd = 11; s.mwb_rd = 11; s.mwb_rw = 1; s.mwb_data = 32'h66;
        applyStimulus(s, mkExp(20, 0, 0, 2'b00, 0, 1, 0));
        s = idleStim(); s.exv = 1; s.id_mr = 1; s.id_rd = 0; s.used = 2'b11;
        s.exm_rd = 0; s.exm_rw = 1; s.exm_data = 32'h99; s.mwb_rd = 0; s.mwb_rw = 1;
        s.mwb_data = 32'h98;
        applyStimulus(s, mkExp(21, 0, 0, 2'b00, 0, 0, 0));
        s = idleStim();
        applyStimulus(s, mkExp(22, 0, 0, 2'b00, 0, 1, 0));
        s = idleStim(); s.exv = 1; s.rs0 = 14; s.used = 2'b01;
        applyStimulus(s, mkExp(23, 0, 0, 2'b00, 1, 1, 0));

        // Response for non-pending x9 raises the sticky error, count unchanged
        s = idleStim(); s.rv = 1; s.rrd = 9;
        applyStimulus(s, mkExp(24, 0, 0, 2'b00, 0, 1, 0));
        s = idleStim();
        applyStimulus(s, withCnt(mkExp(25, 0, 0, 2'b00, 0, 1, 1), 4));
        s = idleStim(); s.rv = 1; s.rrd = 12; s.mwb_rd = 12; s.mwb_rw = 1;
        applyStimulus(s, mkExp(26, 0, 0, 2'b00, 0, 1, 1));
        s = idleStim();
        applyStimulus(s, mkExp(27, 0, 0, 2'b00, 0, 0, 1));

        // Mid-operation reset clears everything; a late response then errors
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        s = idleStim(); s.exv = 1; s.rs0 = 13; s.used = 2'b01;
        applyStimulus(s, withCnt(mkExp(28, 0, 0, 2'b00, 0, 0, 0), 0));
        s = idleStim(); s.rv = 1; s.rrd = 13;
        applyStimulus(s, mkExp(29, 0, 0, 2'b00, 0, 0, 0));
        s = idleStim();
        applyStimulus(s, mkExp(30, 0, 0, 2'b00, 0, 0, 1));

        // Stall counter saturation
        s = idleStim(); s.exv = 1; s.id_mr = 1; s.id_rd = 15;
        applyStimulus(s, mkExp(31, 0, 0, 2'b00, 0, 0, 1));
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cycles_q;
        s = idleStim(); s.exv = 1; s.rs0 = 15; s.used = 2'b01;
        applyStimulus(s, withCnt(mkExp(32, 0, 0, 2'b00, 1, 0, 1), 32'hFFFF_FFFE));
        applyStimulus(s, withCnt(mkExp(33, 0, 0, 2'b00, 1, 0, 1), 32'hFFFF_FFFF));
        applyStimulus(s, withCnt(mkExp(34, 0, 0, 2'b00, 1, 0, 1), 32'hFFFF_FFFF));
        s = idleStim();
        applyStimulus(s, withCnt(mkExp(35, 0, 0, 2'b00, 0, 0, 1), 32'hFFFF_FFFF));

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
